axis_rx_checker: RTL and testbench

//  AXI4-Stream sink sitting directly downstream of the async-FIFO AXI-Stream master.

---
 rtl/axis_rx_checker_if.sv | 13 +
 rtl/axis_rx_checker.sv | 126 ++++++++++++
 tb/tb_axis_rx_checker.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_rx_checker_if.sv
// AXI4-Stream bundle between the upstream async-FIFO master and the rx checker sink.
interface axis_rx_checker_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic                    tvalid;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, output tvalid, output tstrb, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tstrb, input tlast, output tready);
endinterface

// File: rtl/axis_rx_checker.sv
// AXI4-Stream sink that checks an incrementing data pattern, TLAST framing and full TSTRB
// under LFSR back-pressure, exposing beat/packet/error counters for bring-up.
//
// state | meaning
// IDLE  | disabled; TREADY low, counters hold
// SYNC  | waiting for first beat to seed the expected data value
// RUN   | every accepted beat checked against expected data
module axis_rx_checker #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          PKT_LEN     = 256,
    parameter bit          THROTTLE_EN = 1'b1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_rx_checker_if.slave      s_axis,
    input  logic                  chk_en,
    input  logic                  clr,
    output logic [31:0]           beat_count,
    output logic [31:0]           pkt_count,
    output logic [15:0]           data_err_cnt,
    output logic [15:0]           last_err_cnt,
    output logic [15:0]           strb_err_cnt,
    output logic                  err_any,
    output logic [DATA_WIDTH-1:0] first_err_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam int               IDX_W    = $clog2(PKT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    logic [1:0]            state;
    logic [15:0]           lfsr;
    logic [DATA_WIDTH-1:0] expected;
    logic [IDX_W-1:0]      beat_idx;
    logic [IDX_W-1:0]      pos;
    logic                  tready;
    logic                  acc;
    logic                  at_end;
    logic                  data_err;
    logic                  last_err;
    logic                  strb_err;
    logic                  any_err;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic hit);
        return (hit && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    assign tready        = (state != ST_IDLE) && !clr && (!THROTTLE_EN || lfsr[0]);
    assign s_axis.tready = tready;
    assign acc           = s_axis.tvalid && tready;

    // The syncing beat is always beat 0 of a packet, whatever beat_idx held before.
    assign pos      = (state == ST_SYNC) ? '0 : beat_idx;
    assign at_end   = (pos == LAST_IDX);
    assign data_err = acc && (state == ST_RUN) && (s_axis.tdata != expected);
    assign last_err = acc && (s_axis.tlast != at_end);
    assign strb_err = acc && (s_axis.tstrb != '1);
    assign any_err  = data_err || last_err || strb_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (clr) begin
            state <= chk_en ? ST_SYNC : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (chk_en) state <= ST_SYNC;
                ST_SYNC: begin
                    if (!chk_en)  state <= ST_IDLE;
                    else if (acc) state <= ST_RUN;
                end
                ST_RUN:  if (!chk_en) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Fibonacci LFSR, taps 16,14,13,11, shifting left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            lfsr <= LFSR_SEED;
        end else if (state != ST_IDLE) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_count     <= '0;
            pkt_count      <= '0;
            data_err_cnt   <= '0;
            last_err_cnt   <= '0;
            strb_err_cnt   <= '0;
            err_any        <= 1'b0;
            first_err_data <= '0;
            beat_idx       <= '0;
            expected       <= '0;
        end else if (clr) begin
            beat_count     <= '0;
            pkt_count      <= '0;
            data_err_cnt   <= '0;
            last_err_cnt   <= '0;
            strb_err_cnt   <= '0;
            err_any        <= 1'b0;
            first_err_data <= '0;
            beat_idx       <= '0;
        end else if (acc) begin
            beat_count   <= beat_count + 32'd1;
            pkt_count    <= s_axis.tlast ? pkt_count + 32'd1 : pkt_count;
            beat_idx     <= (s_axis.tlast || at_end) ? '0 : pos + IDX_W'(1);
            expected     <= s_axis.tdata + DATA_WIDTH'(1);
            data_err_cnt <= sat_inc(data_err_cnt, data_err);
            last_err_cnt <= sat_inc(last_err_cnt, last_err);
            strb_err_cnt <= sat_inc(strb_err_cnt, strb_err);
            if (any_err) begin
                err_any <= 1'b1;
                if (!err_any) first_err_data <= s_axis.tdata;
            end
        end
    end

endmodule

// File: tb/tb_axis_rx_checker.sv
// Randomized self-checking bench: one unthrottled and one throttled checker driven by
// AXI-compliant sources, compared cycle by cycle with a behavioural model.
module tb_axis_rx_checker;

    localparam int          DW      = 32;
    localparam int          PKT_LEN = 256;
    localparam logic [15:0] SEED    = 16'hACE1;

    localparam int PH_CLEAN = 0;
    localparam int PH_GAP   = 1;
    localparam int PH_FRAME = 2;
    localparam int PH_CTRL  = 3;
    localparam int PH_RAND  = 4;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic chk_en = 1'b0;
    logic clr    = 1'b0;

    always #5 clk = ~clk;

    logic [DW-1:0] tdata  [2];
    logic          tvalid [2];
    logic [3:0]    tstrb  [2];
    logic          tlast  [2];

    logic          d_tready  [2];
    logic [31:0]   d_beats   [2];
    logic [31:0]   d_pkts    [2];
    logic [15:0]   d_derr    [2];
    logic [15:0]   d_lerr    [2];
    logic [15:0]   d_serr    [2];
    logic          d_err_any [2];
    logic [DW-1:0] d_first   [2];

    for (genvar i = 0; i < 2; i++) begin : g_ch
        axis_rx_checker_if #(.DATA_WIDTH(DW)) s_if ();
        assign s_if.tdata   = tdata[i];
        assign s_if.tvalid  = tvalid[i];
        assign s_if.tstrb   = tstrb[i];
        assign s_if.tlast   = tlast[i];
        assign d_tready[i]  = s_if.tready;

        axis_rx_checker #(
            .DATA_WIDTH (DW),
            .PKT_LEN    (PKT_LEN),
            .THROTTLE_EN(i == 1),
            .LFSR_SEED  (SEED)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .s_axis        (s_if),
            .chk_en        (chk_en),
            .clr           (clr),
            .beat_count    (d_beats[i]),
            .pkt_count     (d_pkts[i]),
            .data_err_cnt  (d_derr[i]),
            .last_err_cnt  (d_lerr[i]),
            .strb_err_cnt  (d_serr[i]),
            .err_any       (d_err_any[i]),
            .first_err_data(d_first[i])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    // stimulus generator
    int          phase;
    int          g_k [2];
    int          g_n;
    bit          acc_prev [2];
    logic [31:0] base;
    logic [31:0] rnext [2];

    // reference model
    bit          m_active  [2];
    bit          m_synced  [2];
    logic [15:0] m_lfsr    [2];
    logic [31:0] m_exp     [2];
    int          m_idx     [2];
    logic [31:0] m_beats   [2];
    logic [31:0] m_pkts    [2];
    logic [15:0] m_derr    [2];
    logic [15:0] m_lerr    [2];
    logic [15:0] m_serr    [2];
    bit          m_err_any [2];
    logic [31:0] m_first   [2];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic bit model_tready(input int ch);
        return m_active[ch] && !clr && (ch == 0 || m_lfsr[ch][0]);
    endfunction

    task automatic model_clear(input int ch);
        m_idx[ch]     = 0;
        m_beats[ch]   = '0;
        m_pkts[ch]    = '0;
        m_derr[ch]    = '0;
        m_lerr[ch]    = '0;
        m_serr[ch]    = '0;
        m_err_any[ch] = 1'b0;
        m_first[ch]   = '0;
        m_lfsr[ch]    = SEED;
        m_synced[ch]  = 1'b0;
    endtask

    task automatic model_step(input int ch, input bit trm);
        bit acc, early, missing, de, le, se;
        int pos;
        if (clr) begin
            model_clear(ch);
            m_active[ch] = chk_en;
            return;
        end
        if (m_active[ch]) m_lfsr[ch] = lfsr_next(m_lfsr[ch]);
        acc = tvalid[ch] && trm;
        if (acc) begin
            pos     = m_synced[ch] ? m_idx[ch] : 0;
            early   = tlast[ch] && (pos != PKT_LEN - 1);
            missing = !tlast[ch] && (pos == PKT_LEN - 1);
            de      = m_synced[ch] && (tdata[ch] != m_exp[ch]);
            le      = early || missing;
            se      = (tstrb[ch] != 4'hF);
            m_beats[ch] = m_beats[ch] + 1;
            if (tlast[ch]) m_pkts[ch] = m_pkts[ch] + 1;
            m_idx[ch] = (tlast[ch] || pos == PKT_LEN - 1) ? 0 : pos + 1;
            m_exp[ch] = tdata[ch] + 32'd1;
            if (de && m_derr[ch] != 16'hFFFF) m_derr[ch] = m_derr[ch] + 16'd1;
            if (le && m_lerr[ch] != 16'hFFFF) m_lerr[ch] = m_lerr[ch] + 16'd1;
            if (se && m_serr[ch] != 16'hFFFF) m_serr[ch] = m_serr[ch] + 16'd1;
            if (de || le || se) begin
                if (!m_err_any[ch]) m_first[ch] = tdata[ch];
                m_err_any[ch] = 1'b1;
            end
        end
        if (!m_active[ch]) begin
            m_active[ch] = chk_en;
            m_synced[ch] = 1'b0;
        end else if (!chk_en) begin
            m_active[ch] = 1'b0;
        end else if (acc) begin
            m_synced[ch] = 1'b1;
        end
    endtask

    task automatic cmp_full(input int ch);
        check_val($sformatf("ch%0d pkt_count", ch), d_pkts[ch], m_pkts[ch]);
        check_val($sformatf("ch%0d data_err_cnt", ch), d_derr[ch], m_derr[ch]);
        check_val($sformatf("ch%0d last_err_cnt", ch), d_lerr[ch], m_lerr[ch]);
        check_val($sformatf("ch%0d strb_err_cnt", ch), d_serr[ch], m_serr[ch]);
        check_val($sformatf("ch%0d first_err_data", ch), d_first[ch], m_first[ch]);
    endtask

    task automatic gen_beat(input int ch);
        int          k;
        logic [31:0] d;
        logic        l;
        logic [3:0]  s;
        k = g_k[ch];
        s = 4'hF;
        l = (k % PKT_LEN) == PKT_LEN - 1;
        case (phase)
            PH_CLEAN: d = 32'(k);
            PH_GAP:   d = (k < 100) ? 32'(k) : 32'(k + 1);
            PH_FRAME: begin
                d = base + 32'(k);
                l = (k == 9);
                if (k == 280) s = 4'h7;
            end
            PH_CTRL:  d = base + 32'(k);
            default: begin
                d = rnext[ch];
                if ($urandom_range(39) == 0) d = d + $urandom_range(5, 1);
                if ($urandom_range(59) == 0) l = !l;
                if ($urandom_range(49) == 0) s = 4'($urandom);
                rnext[ch] = d + 32'd1;
            end
        endcase
        tdata[ch] = d;
        tlast[ch] = l;
        tstrb[ch] = s;
    endtask

    // One clock cycle: compare registered outputs, drive inputs, check TREADY, advance model.
    task automatic step(input bit en, input bit c, input bit rebase, input bit full);
        bit trm;
        @(negedge clk);
        for (int ch = 0; ch < 2; ch++) begin
            check_val($sformatf("ch%0d beat_count", ch), d_beats[ch], m_beats[ch]);
            check_val($sformatf("ch%0d err_any", ch), d_err_any[ch], m_err_any[ch]);
            if (full) cmp_full(ch);
        end
        chk_en = en;
        clr    = c;
        if (rebase) base = base + 32'd1000;
        for (int ch = 0; ch < 2; ch++) begin
            if (acc_prev[ch]) begin
                tvalid[ch] = 1'b0;
                g_k[ch]++;
            end
            if (rebase && tvalid[ch]) tdata[ch] = base + 32'(g_k[ch]);
            if (!tvalid[ch] && g_k[ch] < g_n && $urandom_range(3) != 0) begin
                gen_beat(ch);
                tvalid[ch] = 1'b1;
            end
        end
        #1;
        for (int ch = 0; ch < 2; ch++) begin
            trm = model_tready(ch);
            check_val($sformatf("ch%0d tready", ch), d_tready[ch], trm);
            acc_prev[ch] = tvalid[ch] && trm;
            model_step(ch, trm);
        end
    endtask

    task automatic run_until(input int target, input bit rnd_ctl, input string tag);
        int budget;
        int cyc;
        bit en;
        bit c;
        bit done;
        budget = 30 * target + 200;
        cyc    = 0;
        en     = 1'b1;
        done   = 1'b0;
        while (!done && cyc < budget) begin
            c = 1'b0;
            if (rnd_ctl) begin
                if (en && $urandom_range(149) == 0) en = 1'b0;
                else if (!en && $urandom_range(7) == 0) en = 1'b1;
                c = ($urandom_range(299) == 0);
            end
            step(en, c, 1'b0, 1'b0);
            cyc++;
            done = (g_k[0] >= target) && (g_k[1] >= target);
        end
        check_val({tag, " finished within budget"}, done, 1'b1);
    endtask

    task automatic start_phase(input int ph, input int n);
        phase = ph;
        g_n   = n;
        for (int ch = 0; ch < 2; ch++) g_k[ch] = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        for (int ch = 0; ch < 2; ch++) begin
            tdata[ch]    = '0;
            tvalid[ch]   = 1'b0;
            tstrb[ch]    = 4'hF;
            tlast[ch]    = 1'b0;
            acc_prev[ch] = 1'b0;
            g_k[ch]      = 0;
            rnext[ch]    = $urandom;
            model_clear(ch);
            m_active[ch] = 1'b0;
            m_exp[ch]    = '0;
        end
        g_n    = 0;
        phase  = PH_CLEAN;
        base   = '0;
        chk_en = 1'b1;
        rst    = 1'b1;

        repeat (3) begin
            @(negedge clk);
            #1;
            for (int ch = 0; ch < 2; ch++) begin
                check_val($sformatf("ch%0d rst tready", ch), d_tready[ch], 1'b0);
                check_val($sformatf("ch%0d rst beat_count", ch), d_beats[ch], 32'd0);
                check_val($sformatf("ch%0d rst err_any", ch), d_err_any[ch], 1'b0);
                cmp_full(ch);
            end
        end
        rst = 1'b0;
        for (int ch = 0; ch < 2; ch++) model_step(ch, model_tready(ch));

        // clean stream straight out of reset
        phase = PH_CLEAN;
        g_n   = 1024;
        run_until(1024, 1'b0, "clean");
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int ch = 0; ch < 2; ch++) begin
            check_val($sformatf("ch%0d clean beats", ch), d_beats[ch], 32'd1024);
            check_val($sformatf("ch%0d clean pkts", ch), d_pkts[ch], 32'd4);
            check_val($sformatf("ch%0d clean errs", ch),
                      {d_derr[ch], d_lerr[ch], d_serr[ch]}, 48'd0);
            check_val($sformatf("ch%0d clean err_any", ch), d_err_any[ch], 1'b0);
        end

        // missing value 100 in the data sequence
        start_phase(PH_GAP, 300);
        run_until(300, 1'b0, "gap");
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int ch = 0; ch < 2; ch++) begin
            check_val($sformatf("ch%0d gap data_err", ch), d_derr[ch], 16'd1);
            check_val($sformatf("ch%0d gap first_err", ch), d_first[ch], 32'd101);
            check_val($sformatf("ch%0d gap beats", ch), d_beats[ch], 32'd300);
        end

        // early TLAST, missing TLAST and a partial strobe
        base = $urandom;
        start_phase(PH_FRAME, 290);
        run_until(290, 1'b0, "frame");
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int ch = 0; ch < 2; ch++) begin
            check_val($sformatf("ch%0d frame last_err", ch), d_lerr[ch], 16'd2);
            check_val($sformatf("ch%0d frame pkts", ch), d_pkts[ch], 32'd1);
            check_val($sformatf("ch%0d frame strb_err", ch), d_serr[ch], 16'd1);
            check_val($sformatf("ch%0d frame data_err", ch), d_derr[ch], 16'd0);
            check_val($sformatf("ch%0d frame first_err", ch), d_first[ch], base + 32'd9);
        end

        // disable mid-packet, then clear with a beat pending
        base = $urandom;
        start_phase(PH_CTRL, 60);
        run_until(50, 1'b0, "ctrl");
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int ch = 0; ch < 2; ch++)
            check_val($sformatf("ch%0d clr tready", ch), d_tready[ch], 1'b0);
        g_n = 100;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int ch = 0; ch < 2; ch++) begin
            check_val($sformatf("ch%0d clr beats", ch), d_beats[ch], 32'd0);
            check_val($sformatf("ch%0d clr errs", ch),
                      {d_derr[ch], d_lerr[ch], d_serr[ch]}, 48'd0);
        end
        run_until(100, 1'b0, "ctrl resync");
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int ch = 0; ch < 2; ch++)
            check_val($sformatf("ch%0d resync data_err", ch), d_derr[ch], 16'd0);

        // random traffic, random enable toggles and clears
        start_phase(PH_RAND, 3000);
        run_until(3000, 1'b1, "random");
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
